// File: rtl/reg_file.sv
// Two-read, one-write register file with r0 hardwired to zero, optional same-cycle
// write-to-read forwarding, an unforwarded debug read port and a saturating write counter.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [15:0]           wr_count
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [15:0] CountMax = 16'hFFFF;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [15:0]           wr_count_q;
  logic                  commit;
  logic                  fwd1;
  logic                  fwd2;
  logic [DATA_WIDTH-1:0] stored1;
  logic [DATA_WIDTH-1:0] stored2;
  logic [DATA_WIDTH-1:0] stored_dbg;

  // Writes to r0 and writes during reset are dropped; reset wins over a same-edge write.
  assign commit = we & ~rst & (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (commit && (wr_count_q != CountMax)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // r0 is forced to zero on every read path, so it holds even before the first reset.
  always_comb begin
    stored1    = (raddr1 == '0) ? '0 : regs_q[raddr1];
    stored2    = (raddr2 == '0) ? '0 : regs_q[raddr2];
    stored_dbg = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  end

  always_comb begin
    fwd1 = (BYPASS != 0) && commit && (waddr == raddr1);
    fwd2 = (BYPASS != 0) && commit && (waddr == raddr2);
  end

  always_comb begin
    rdata1   = '0;
    rdata2   = '0;
    dbg_data = '0;
    if (!rst) begin
      rdata1   = fwd1 ? wdata : stored1;
      rdata2   = fwd2 ? wdata : stored2;
      dbg_data = stored_dbg;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a forwarding and a non-forwarding instance share stimulus
// and are checked against a behavioural model through an expected-result queue.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [4:0]  dbg_addr;
  logic [31:0] rdata1, rdata2, dbg_data;
  logic [15:0] wr_count;
  logic [31:0] nb_rdata1, nb_rdata2, nb_dbg_data;
  logic [15:0] nb_wr_count;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
    logic [31:0] r1nb;
    logic [31:0] r2nb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [32];
  logic [15:0] mcnt;
  int          n_total = 0;
  int          n_bad   = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .wr_count(nb_wr_count)
  );

  initial forever #5 clk = ~clk;

  // Advance one rising edge and apply its effect to the model.
  task automatic tick();
    logic        c, r;
    logic [4:0]  a;
    logic [31:0] d;
    c = we && !rst && (waddr != 5'd0);
    r = rst;
    a = waddr;
    d = wdata;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mcnt = 16'h0;
    end else if (c) begin
      mdl[a] = d;
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end
    #1;
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic c;
    c = we && !rst && (waddr != 5'd0);
    e.cnt = mcnt;
    if (rst) begin
      e.r1 = 32'h0; e.r2 = 32'h0; e.dbg = 32'h0; e.r1nb = 32'h0; e.r2nb = 32'h0;
    end else begin
      e.r1nb = (raddr1 == 5'd0) ? 32'h0 : mdl[raddr1];
      e.r2nb = (raddr2 == 5'd0) ? 32'h0 : mdl[raddr2];
      e.r1   = (c && waddr == raddr1) ? wdata : e.r1nb;
      e.r2   = (c && waddr == raddr2) ? wdata : e.r2nb;
      e.dbg  = (dbg_addr == 5'd0) ? 32'h0 : mdl[dbg_addr];
    end
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
    raddr1 = 5'd3; raddr2 = 5'd3; dbg_addr = 5'd3;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0 || nb_rdata1 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_gating got r1=%h r2=%h dbg=%h nb=%h exp all 0",
               rdata1, rdata2, dbg_data, nb_rdata1);
    end
    tick();
    tick();
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      exp_q.push_back(predict());
      e = exp_q.pop_front();
      n_total++;
      if (rdata1 !== e.r1 || rdata2 !== e.r2 || dbg_data !== e.dbg || wr_count !== e.cnt
          || nb_rdata1 !== e.r1nb || nb_rdata2 !== e.r2nb) begin
        n_bad++;
        $display("FAIL reset_sweep[%0d] got %h %h %h %h cnt=%h exp %h %h %h %h cnt=%h", i,
                 rdata1, rdata2, dbg_data, nb_rdata1, wr_count, e.r1, e.r2, e.dbg, e.r1nb, e.cnt);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5; dbg_addr = 5'd5;
    #1;
    n_total++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF
        || nb_rdata1 !== 32'hDEADBEEF || wr_count !== 16'd1) begin
      n_bad++;
      $display("FAIL write_read got r1=%h r2=%h dbg=%h nb=%h cnt=%0d exp deadbeef x4 cnt=1",
               rdata1, rdata2, dbg_data, nb_rdata1, wr_count);
    end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_bad++;
      $display("FAIL r0_no_forward got r1=%h r2=%h exp 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0 || wr_count !== 16'd1) begin
      n_bad++;
      $display("FAIL r0_discard got r1=%h r2=%h dbg=%h cnt=%0d exp 0 0 0 cnt=1",
               rdata1, rdata2, dbg_data, wr_count);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5; raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
    #1;
    n_total++;
    if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5 || dbg_data !== 32'h1) begin
      n_bad++;
      $display("FAIL bypass_on got r1=%h r2=%h dbg=%h exp a5a5a5a5 a5a5a5a5 1",
               rdata1, rdata2, dbg_data);
    end
    n_total++;
    if (nb_rdata1 !== 32'h1 || nb_rdata2 !== 32'h1 || nb_dbg_data !== 32'h1) begin
      n_bad++;
      $display("FAIL bypass_off got r1=%h r2=%h dbg=%h exp 1 1 1",
               nb_rdata1, nb_rdata2, nb_dbg_data);
    end
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rdata1 !== 32'hA5A5A5A5 || nb_rdata1 !== 32'hA5A5A5A5 || dbg_data !== 32'hA5A5A5A5
        || wr_count !== 16'd3) begin
      n_bad++;
      $display("FAIL bypass_next got r1=%h nb=%h dbg=%h cnt=%0d exp a5a5a5a5 x3 cnt=3",
               rdata1, nb_rdata1, dbg_data, wr_count);
    end
  endtask

  task automatic test_same_value();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (wr_count !== 16'd4) begin
      n_bad++;
      $display("FAIL same_value_count got=%0d exp=4", wr_count);
    end
  endtask

  task automatic test_mid_cycle_reset();
    raddr1 = 5'd5; raddr2 = 5'd7; dbg_addr = 5'd5; rst = 1'b1;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0) begin
      n_bad++;
      $display("FAIL async_gate got r1=%h r2=%h dbg=%h exp 0 0 0", rdata1, rdata2, dbg_data);
    end
    rst = 1'b0;
    #1;
    tick();
    n_total++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hA5A5A5A5 || wr_count !== 16'd4) begin
      n_bad++;
      $display("FAIL async_no_state got r1=%h r2=%h cnt=%0d exp deadbeef a5a5a5a5 cnt=4",
               rdata1, rdata2, wr_count);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 7));
      #1;
      exp_q.push_back(predict());
      e = exp_q.pop_front();
      n_total++;
      if (rdata1 !== e.r1 || rdata2 !== e.r2 || dbg_data !== e.dbg || wr_count !== e.cnt
          || nb_rdata1 !== e.r1nb || nb_rdata2 !== e.r2nb || nb_wr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL random[%0d] got %h %h %h %h %h cnt=%h exp %h %h %h %h %h cnt=%h", i,
                 rdata1, rdata2, dbg_data, nb_rdata1, nb_rdata2, wr_count,
                 e.r1, e.r2, e.dbg, e.r1nb, e.r2nb, e.cnt);
      end
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset_priority();
    we = 1'b1; waddr = 5'd31; wdata = 32'hFFFFFFFF;
    tick();
    rst = 1'b1; wdata = 32'h5; raddr1 = 5'd31; raddr2 = 5'd31; dbg_addr = 5'd31;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_write_gate got r1=%h r2=%h dbg=%h exp 0 0 0", rdata1, rdata2, dbg_data);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    n_total++;
    if (rdata1 !== 32'h0 || dbg_data !== 32'h0 || wr_count !== 16'd0 || nb_wr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_priority got r31=%h dbg=%h cnt=%0d exp 0 0 cnt=0",
               rdata1, dbg_data, wr_count);
    end
    we = 1'b1; wdata = 32'h9;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rdata1 !== 32'h9 || wr_count !== 16'd1) begin
      n_bad++;
      $display("FAIL first_after_rst got r31=%h cnt=%0d exp 9 cnt=1", rdata1, wr_count);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd1; raddr1 = 5'd1; raddr2 = 5'd2; dbg_addr = 5'd1;
    for (int i = 0; i < 65540; i++) begin
      wdata = 32'(i);
      tick();
      if (i == 65533 || i == 65534 || i == 65539) begin
        we = 1'b0;
        #1;
        exp_q.push_back(predict());
        e = exp_q.pop_front();
        n_total++;
        if (wr_count !== e.cnt || dbg_data !== e.dbg) begin
          n_bad++;
          $display("FAIL saturate[%0d] got cnt=%h r1=%h exp cnt=%h r1=%h",
                   i, wr_count, dbg_data, e.cnt, e.dbg);
        end
        we = 1'b1;
      end
    end
    we = 1'b0;
    #1;
    n_total++;
    if (wr_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL saturate_final got=%h exp=ffff", wr_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mcnt = 16'h0;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_same_value();
    test_mid_cycle_reset();
    test_random();
    test_reset_priority();
    test_saturate();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each register and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width; depth is 2**ADDR_WIDTH (32 entries).
REQ-003 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored contents only.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 we  input  1  write enable for write port.
REQ-007 waddr  input  ADDR_WIDTH  write register index.
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 raddr1  input  ADDR_WIDTH  read port 1 index (drives ALU operand a).
REQ-010 raddr2  input  ADDR_WIDTH  read port 2 index (drives ALU operand b).
REQ-011 rdata1  output  DATA_WIDTH  read port 1 data, combinational.
REQ-012 rdata2  output  DATA_WIDTH  read port 2 data, combinational.
REQ-013 dbg_addr  input  ADDR_WIDTH  debug read index.
REQ-014 dbg_data  output  DATA_WIDTH  debug read data, stored contents only, never bypassed.
REQ-015 wr_count  output  16  count of committed writes to nonzero registers since reset.

Function
REQ-016 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits; register 0 SHALL read as 0 on every port at all times.
REQ-017 Write SHALL commit on the rising clk edge when we=1, rst=0, waddr!=0; written value visible in stored contents from the next cycle.
REQ-018 Writes with waddr=0 SHALL be discarded and SHALL NOT increment wr_count.
REQ-019 Read ports SHALL be combinational, zero-latency: rdataN = reg[raddrN] in the same cycle.
REQ-020 With BYPASS=1: when we=1, rst=0, waddr!=0 and waddr==raddrN, rdataN SHALL equal wdata in that same cycle.
REQ-021 With BYPASS=0: under the REQ-020 condition, rdataN SHALL equal the old stored value; new value appears next cycle.
REQ-022 Both read ports SHALL resolve independently; raddr1==raddr2 SHALL return identical data on both.
REQ-023 While rst=1, rdata1, rdata2 and dbg_data SHALL be 0 (combinational gating).
REQ-024 wr_count SHALL increment by 1 per committed write (REQ-017); it SHALL saturate at 16'hFFFF and never wrap.
REQ-025 Rewriting the same value SHALL still count as a committed write.
REQ-026 X/undefined addresses are not supported; no out-of-range case exists (full decode).

Reset
REQ-027 On a rising edge with rst=1, all registers SHALL clear to 0 and wr_count SHALL clear to 0.
REQ-028 A write presented in a cycle with rst=1 SHALL be discarded and SHALL NOT be forwarded.
REQ-029 Reset asserted mid-sequence SHALL take priority over any pending write in that same edge; first write after deassertion commits normally.
REQ-030 No state SHALL change asynchronously; asserting rst between edges SHALL affect only the combinational gating of REQ-023.

Verification
REQ-031 Reset then read all 32 indices on both ports and debug -> all 0; wr_count=0.
REQ-032 Write 0xDEADBEEF to r5, next cycle raddr1=5, raddr2=5 -> both 0xDEADBEEF; dbg_addr=5 -> 0xDEADBEEF; wr_count=1.
REQ-033 Write 0x12345678 to r0, next cycle read r0 -> 0; wr_count unchanged.
REQ-034 r7 holds 0x1; same cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 -> BYPASS=1: rdata1=0xA5A5A5A5, dbg_data=0x1; BYPASS=0: rdata1=0x1; next cycle both 0xA5A5A5A5.
REQ-035 Write 0xFFFFFFFF to r31, then assert rst with we=1, waddr=31, wdata=0x5 for one edge -> rdata during rst=0, after deassert r31 reads 0, wr_count=0.
REQ-036 Issue 65540 writes to r1 (force counter to 16'hFFFE first if bench time-limited) -> wr_count holds 16'hFFFF, does not wrap to 0.
